// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// Single outstanding request; the memory answers with dmem_ready/dmem_rdata.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_rdata,
        output dmem_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: multi-cycle data-memory access with store lane formatting and load extension.
// Define MEM_MISALIGN_CHK_EN to reject misaligned half/word accesses instead of issuing them.
module mem_access_stage (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      EX_MEM_MemRead,
    input  logic                      EX_MEM_MemWrite,
    input  logic [31:0]               EX_MEM_ALUout,
    input  logic [31:0]               EX_MEM_RD2,
    input  logic [2:0]                EX_MEM_Funct3,
    mem_access_stage_if.master        dmem,
    output logic [31:0]               MEMout,
    output logic                      mem_stall,
    output logic                      mem_misalign
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        we_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] memout_q;

    logic        access;
    logic        is_load;
    logic        size_byte;
    logic        size_half;
    logic        misaligned;
    logic        start;
    logic        busy;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;
    logic        load_done;

    assign access  = EX_MEM_MemRead | EX_MEM_MemWrite;
    // A read wins when both are set, so the write is simply dropped.
    assign is_load = EX_MEM_MemRead;

    always_comb begin
        size_byte = 1'b0;
        size_half = 1'b0;
        if (is_load) begin
            case (EX_MEM_Funct3)
                3'b000, 3'b100: size_byte = 1'b1;
                3'b001, 3'b101: size_half = 1'b1;
                default:        ;
            endcase
        end else begin
            case (EX_MEM_Funct3)
                3'b000:  size_byte = 1'b1;
                3'b001:  size_half = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    assign misaligned = access &
                        (size_half ? EX_MEM_ALUout[0]
                                   : (!size_byte && (EX_MEM_ALUout[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign start = (state_q == StIdle) & access & ~misaligned;
    assign busy  = (state_q == StBusy);

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = EX_MEM_RD2;
        if (size_byte) begin
            be_n    = 4'b0001 << EX_MEM_ALUout[1:0];
            wdata_n = {4{EX_MEM_RD2[7:0]}};
        end else if (size_half) begin
            be_n    = EX_MEM_ALUout[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{EX_MEM_RD2[15:0]}};
        end
        if (is_load) begin
            be_n = 4'b1111;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StBusy;
            StBusy:  if (dmem.dmem_ready) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    load_byte = dmem.dmem_rdata[7:0];
            2'd1:    load_byte = dmem.dmem_rdata[15:8];
            2'd2:    load_byte = dmem.dmem_rdata[23:16];
            default: load_byte = dmem.dmem_rdata[31:24];
        endcase
        load_half = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_val = {{16{load_half[15]}}, load_half};
            3'b100:  load_val = {24'h0, load_byte};
            3'b101:  load_val = {16'h0, load_half};
            default: load_val = dmem.dmem_rdata;
        endcase
    end

    assign load_done = busy & dmem.dmem_ready & ~we_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            funct3_q <= '0;
            off_q    <= '0;
            memout_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                we_q     <= ~is_load;
                addr_q   <= EX_MEM_ALUout[31:2];
                wdata_q  <= wdata_n;
                be_q     <= be_n;
                funct3_q <= EX_MEM_Funct3;
                off_q    <= EX_MEM_ALUout[1:0];
            end
            if (load_done) begin
                memout_q <= load_val;
            end
        end
    end

    // Bus outputs are zero outside BUSY so the memory sees a quiet bus between requests.
    assign dmem.dmem_req   = busy;
    assign dmem.dmem_we    = busy & we_q;
    assign dmem.dmem_addr  = busy ? {addr_q, 2'b00} : 32'h0;
    assign dmem.dmem_wdata = busy ? wdata_q : 32'h0;
    assign dmem.dmem_be    = busy ? be_q : 4'h0;

    assign MEMout       = memout_q;
    assign mem_stall    = start | busy;
    assign mem_misalign = rstn & (state_q == StIdle) & misaligned;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed corner cases plus random accesses against a lane model.
module tb_mem_access_stage;

`ifdef MEM_MISALIGN_CHK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] alu_out;
    logic [31:0] rd2;
    logic [2:0]  funct3;
    logic [31:0] mem_out;
    logic        mem_stall;
    logic        mem_misalign;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_memout = 32'h0;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk             (clk),
        .rstn            (rstn),
        .EX_MEM_MemRead  (mem_read),
        .EX_MEM_MemWrite (mem_write),
        .EX_MEM_ALUout   (alu_out),
        .EX_MEM_RD2      (rd2),
        .EX_MEM_Funct3   (funct3),
        .dmem            (bus.master),
        .MEMout          (mem_out),
        .mem_stall       (mem_stall),
        .mem_misalign    (mem_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Access width in bytes as the ISA defines it; reads take precedence over writes.
    function automatic int size_of(input bit rd, input logic [2:0] fn);
        if (rd) begin
            if (fn == 3'd0 || fn == 3'd4) return 1;
            if (fn == 3'd1 || fn == 3'd5) return 2;
            return 4;
        end
        if (fn == 3'd0) return 1;
        if (fn == 3'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] fn, input int off,
                                               input logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (fn)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    task automatic clear_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_out   = $urandom;
        rd2       = $urandom;
        funct3    = 3'($urandom);
    endtask

    // Called just after a rising edge with the DUT idle; returns the same way.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] fn, input int delay,
                              input logic [31:0] word);
        int          sz;
        int          off;
        bit          mis;
        int          stalls;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        sz     = size_of(rd, fn);
        off    = int'(a[1:0]);
        mis    = ChkEn && ((sz == 2 && a[0]) || (sz == 4 && off != 0));
        stalls = 0;
        exp_be    = 4'hF;
        exp_wdata = d;
        if (!rd && sz == 1) begin
            exp_be    = 4'(1 << off);
            exp_wdata = {24'h0, d[7:0]} * 32'h0101_0101;
        end else if (!rd && sz == 2) begin
            exp_be    = (off >= 2) ? 4'hC : 4'h3;
            exp_wdata = {16'h0, d[15:0]} * 32'h0001_0001;
        end
        mem_read       = rd;
        mem_write      = wr;
        alu_out        = a;
        rd2            = d;
        funct3         = fn;
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        check("idle_req", 32'(bus.dmem_req), 32'h0);
        check("idle_misalign", 32'(mem_misalign), 32'(mis));
        if (mem_stall) stalls++;
        if (mis) begin
            check("mis_stall", 32'(mem_stall), 32'h0);
            @(posedge clk);
            #1 clear_inputs();
            @(negedge clk);
            check("mis_no_req", 32'(bus.dmem_req), 32'h0);
            check("mis_memout", mem_out, exp_memout);
            @(posedge clk);
            #1;
            return;
        end
        for (int b = 0; b <= delay; b++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_stall) stalls++;
            check("busy_req", 32'(bus.dmem_req), 32'h1);
            check("busy_we", 32'(bus.dmem_we), 32'(wr && !rd));
            check("busy_addr", bus.dmem_addr, {a[31:2], 2'b00});
            check("busy_be", 32'(bus.dmem_be), 32'(exp_be));
            if (!rd) check("busy_wdata", bus.dmem_wdata, exp_wdata);
            bus.dmem_ready = (b == delay);
            bus.dmem_rdata = (b == delay) ? word : $urandom;
        end
        @(posedge clk);
        #1;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = $urandom;
        if (rd) exp_memout = load_model(fn, off, word);
        @(negedge clk);
        check("done_req", 32'(bus.dmem_req), 32'h0);
        check("done_stall", 32'(mem_stall), 32'h0);
        check("done_memout", mem_out, exp_memout);
        check("stall_cycles", 32'(stalls), 32'(delay + 2));
        clear_inputs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] ld_f3 [8];
        bit         rd;
        bit         wr;
        logic [2:0] fn;
        int         mode;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        // Reset with a misaligned-looking load pending: everything must read as zero.
        rstn           = 1'b0;
        mem_read       = 1'b1;
        mem_write      = 1'b0;
        alu_out        = 32'h101;
        rd2            = 32'h5555_AAAA;
        funct3         = 3'd2;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
        #12;
        check("rst_req", 32'(bus.dmem_req), 32'h0);
        check("rst_we", 32'(bus.dmem_we), 32'h0);
        check("rst_be", 32'(bus.dmem_be), 32'h0);
        check("rst_addr", bus.dmem_addr, 32'h0);
        check("rst_wdata", bus.dmem_wdata, 32'h0);
        check("rst_memout", mem_out, 32'h0);
        check("rst_misalign", 32'(mem_misalign), 32'h0);
        clear_inputs();
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Stray ready while idle must be ignored.
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ready_req", 32'(bus.dmem_req), 32'h0);
            check("idle_ready_stall", 32'(mem_stall), 32'h0);
            check("idle_ready_memout", mem_out, exp_memout);
        end
        @(posedge clk);
        #1 bus.dmem_ready = 1'b0;

        run_access(1'b1, 1'b0, 32'h100, 32'h0, 3'd2, 0, 32'hDEAD_BEEF);
        check("lw_deadbeef", mem_out, 32'hDEAD_BEEF);
        run_access(1'b1, 1'b0, 32'h103, 32'h0, 3'd0, 1, 32'h80FF_0000);
        check("lb_sign", mem_out, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 32'h103, 32'h0, 3'd4, 0, 32'h80FF_0000);
        check("lbu_zero", mem_out, 32'h0000_0080);
        run_access(1'b0, 1'b1, 32'h202, 32'h1234_ABCD, 3'd1, 2, 32'h0);
        check("sh_keeps_memout", mem_out, 32'h0000_0080);
        run_access(1'b1, 1'b1, 32'h40, 32'h7777_7777, 3'd2, 1, 32'h0BAD_F00D);
        run_access(1'b1, 1'b0, 32'h101, 32'h0, 3'd2, 0, 32'h1357_9BDF);
        run_access(1'b1, 1'b0, 32'h306, 32'h0, 3'd1, 0, 32'hC001_2345);
        check("lh_upper", mem_out, 32'hFFFF_C001);

        // Reset in the second BUSY cycle abandons the load.
        mem_read  = 1'b1;
        mem_write = 1'b0;
        alu_out   = 32'h300;
        funct3    = 3'd2;
        @(posedge clk);
        @(negedge clk);
        check("rb_busy1", 32'(bus.dmem_req), 32'h1);
        bus.dmem_rdata = 32'hAAAA_5555;
        @(posedge clk);
        #2 rstn = 1'b0;
        exp_memout = 32'h0;
        #1;
        check("rb_req", 32'(bus.dmem_req), 32'h0);
        check("rb_memout", mem_out, 32'h0);
        clear_inputs();
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rb_idle_req", 32'(bus.dmem_req), 32'h0);
        check("rb_idle_stall", 32'(mem_stall), 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 60; i++) begin
            mode = int'($urandom_range(0, 2));
            rd   = (mode != 1);
            wr   = (mode != 0);
            fn   = rd ? ld_f3[$urandom_range(0, 7)] : 3'($urandom_range(0, 2));
            run_access(rd, wr, $urandom, $urandom, fn, int'($urandom_range(0, 3)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have EX_MEM_MemRead  in  1  load in the EX/MEM register.
REQ-005 SHALL have EX_MEM_MemWrite  in  1  store in the EX/MEM register.
REQ-006 SHALL have EX_MEM_ALUout  in  32  effective byte address.
REQ-007 SHALL have EX_MEM_RD2  in  32  store data, unaligned, in low bits.
REQ-008 SHALL have EX_MEM_Funct3  in  3  access size/sign, RV32I encoding.
REQ-009 SHALL have dmem_req  out  1  memory request valid.
REQ-010 SHALL have dmem_we  out  1  request is a write.
REQ-011 SHALL have dmem_addr  out  32  word-aligned address, {ALUout[31:2],2'b00}.
REQ-012 SHALL have dmem_wdata  out  32  lane-replicated store data.
REQ-013 SHALL have dmem_be  out  4  byte enables.
REQ-014 SHALL have dmem_rdata  in  32  read word, valid when dmem_ready=1.
REQ-015 SHALL have dmem_ready  in  1  memory completes the current request.
REQ-016 SHALL have MEMout  out  32  extended load result, feeds the MEM/WB register.
REQ-017 SHALL have mem_stall  out  1  freeze IF..EX/MEM, insert bubble into MEM/WB.
REQ-018 SHALL have mem_misalign  out  1  misaligned access flag, one cycle.

Function
REQ-019 SHALL implement FSM IDLE, BUSY, DONE; access = MemRead|MemWrite.
REQ-020 IDLE: access -> BUSY, registering we, addr, wdata, be, funct3, byte offset; else stay.
REQ-021 BUSY: dmem_req=1, outputs from registers, held stable until dmem_ready=1 sampled, then DONE.
REQ-022 DONE: load result registered into MEMout; mem_stall=0; next state IDLE unconditionally.
REQ-023 mem_stall SHALL be combinational: (IDLE & access) | BUSY.
REQ-024 Minimum access: 2 stall cycles (IDLE, BUSY with ready) then DONE; each extra not-ready cycle adds one.
REQ-025 Load extension: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero, other = LW.
REQ-026 Load lane select: byte by addr[1:0], half by addr[1].
REQ-027 Stores: SB be=4'b0001<<addr[1:0], wdata={4{byte}}; SH be=addr[1]?1100:0011, wdata={2{half}}; SW be=1111.
REQ-028 Stores SHALL leave MEMout unchanged; loads set dmem_be=1111, dmem_we=0.
REQ-029 MemRead and MemWrite both 1: read performed, write dropped.
REQ-030 dmem_ready outside BUSY SHALL be ignored; dmem_rdata outside BUSY-with-ready SHALL not be sampled.
REQ-031 mem_misalign SHALL be 0 when REQ-036 is not compiled in.

Reset
REQ-032 rstn=0 SHALL force IDLE immediately, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, MEMout=0, mem_misalign=0.
REQ-033 Reset during BUSY SHALL abandon the request; no MEMout update; first post-reset cycle is IDLE.

Configuration
REQ-034 Macro MEM_MISALIGN_CHK_EN SHALL select misalignment checking.
REQ-035 Undefined: LW/SW ignore addr[1:0], LH/SH ignore addr[0]; mem_misalign tied 0.
REQ-036 Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0 -> no request, FSM stays IDLE, mem_stall=0, mem_misalign=1 combinationally that cycle, MEMout unchanged.

Verification
REQ-037 LW addr 0x100, ready in first BUSY cycle, rdata 0xDEADBEEF -> stall 2 cycles, MEMout=0xDEADBEEF in DONE.
REQ-038 LB addr 0x103, rdata 0x80FF_0000 -> MEMout=0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 SH addr 0x202, RD2=0x1234ABCD, ready after 3 BUSY cycles -> be=1100, wdata=0xABCDABCD stable, stall 4 cycles.
REQ-040 rstn low in 2nd BUSY cycle -> dmem_req=0 same cycle, MEMout=0, IDLE after release.
REQ-041 MEM_MISALIGN_CHK_EN defined, LW addr 0x101 -> mem_misalign=1, dmem_req never 1, stall 0; undefined -> request to 0x100.
REQ-042 dmem_ready=1 while IDLE, no access -> no state change, MEMout unchanged.
